fp_mult_iter: RTL and testbench

FP_MULT_ITER -- requirements
Module: fp_mult_iter

---
 rtl/fp_mult_iter_if.sv | 37 +++
 rtl/fp_mult_iter.sv | 251 +++++++++++++++++++++++++
 tb/tb_fp_mult_iter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mult_iter_if.sv
// ---------------------------------------------------------------------------
// fp_mult_iter_if
// Handshake/data bundle for the iterative floating-point multiplier.
//   in_valid / in_ready  : operand handshake (a, b, rnd_mode qualified by it)
//   a, b                 : {sign, exponent, fraction} operands, W bits each
//   rnd_mode             : 0 = round-to-nearest-even, 1 = truncate
//   out_valid / out_ready: result handshake
//   result               : product, W bits
//   flags                : {nan, inf, zero, overflow, underflow}
// master drives operands and out_ready; slave is the multiplier.
// ---------------------------------------------------------------------------
interface fp_mult_iter_if #(
  parameter int EW = 8,
  parameter int FW = 23
);
  localparam int W = 1 + EW + FW;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  modport master (
    output in_valid, a, b, rnd_mode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, rnd_mode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mult_iter.sv
// ---------------------------------------------------------------------------
// fp_mult_iter
// Iterative IEEE-style multiplier: radix-4 Booth, one digit per cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fp_mult_iter_if.slave (operand/result handshakes, see interface)
// Flow: IDLE accepts an operand pair. Special operands (zero/denormal, inf,
// NaN) resolve straight to DONE. Normal*normal runs N Booth cycles, one
// NORM cycle (normalise, round, range check) and then waits in DONE until
// the consumer takes the result.
// ---------------------------------------------------------------------------
module fp_mult_iter #(
  parameter int EW = 8,
  parameter int FW = 23
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_mult_iter_if.slave bus
);

  localparam int W    = 1 + EW + FW;
  localparam int MW   = FW + 1;             // mantissa with hidden bit
  localparam int N    = (FW + 3) / 2;       // Booth digits
  localparam int H    = MW + 3;             // signed high accumulator part
  localparam int AW   = H + 2 * N + 1;      // {high, multiplier, prev bit}
  localparam int PW   = 2 * MW;             // product width
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int EXW  = EW + 2;             // exponent math never wraps
  localparam int BIAS = (1 << (EW - 1)) - 1;

  localparam logic [CW-1:0]         CNT_LAST = CW'(N - 1);
  localparam logic signed [EXW-1:0] EXP_SAT  = EXW'((1 << EW) - 1);
  localparam logic signed [EXW-1:0] EXP_ZERO = {EXW{1'b0}};
  localparam logic [W-1:0]          QNAN     = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BOOTH = 2'd1,
    ST_NORM  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [AW-1:0]           r_acc;
  logic [MW-1:0]           r_mcand;
  logic signed [EXW-1:0]   r_exp;
  logic                    r_sign;
  logic                    r_rnd;
  logic [W-1:0]            r_result;
  logic [4:0]              r_flags;
  logic                    r_out_valid;

  // ---------------- operand classification (at the accepting edge) -------
  logic [EW-1:0] w_ea, w_eb;
  logic [FW-1:0] w_fa, w_fb;
  logic          w_sign;
  logic          w_a_zero, w_a_inf, w_a_nan;
  logic          w_b_zero, w_b_inf, w_b_nan;
  logic          w_special;

  assign w_ea      = bus.a[W-2:FW];
  assign w_fa      = bus.a[FW-1:0];
  assign w_eb      = bus.b[W-2:FW];
  assign w_fb      = bus.b[FW-1:0];
  assign w_sign    = bus.a[W-1] ^ bus.b[W-1];
  // Denormals have a zero exponent and are flushed to zero.
  assign w_a_zero  = (w_ea == {EW{1'b0}});
  assign w_a_inf   = (w_ea == {EW{1'b1}}) && (w_fa == {FW{1'b0}});
  assign w_a_nan   = (w_ea == {EW{1'b1}}) && (w_fa != {FW{1'b0}});
  assign w_b_zero  = (w_eb == {EW{1'b0}});
  assign w_b_inf   = (w_eb == {EW{1'b1}}) && (w_fb == {FW{1'b0}});
  assign w_b_nan   = (w_eb == {EW{1'b1}}) && (w_fb != {FW{1'b0}});
  assign w_special = w_a_zero | w_a_inf | w_a_nan | w_b_zero | w_b_inf | w_b_nan;

  logic [W-1:0] w_sp_result;
  logic [4:0]   w_sp_flags;

  // Result for operand pairs that bypass the Booth datapath.
  always_comb begin
    w_sp_result = {W{1'b0}};
    w_sp_flags  = 5'b00000;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      w_sp_result = QNAN;
      w_sp_flags  = 5'b10000;
    end else if (w_a_inf || w_b_inf) begin
      w_sp_result = {w_sign, {EW{1'b1}}, {FW{1'b0}}};
      w_sp_flags  = 5'b01000;
    end else begin
      w_sp_result = {w_sign, {(EW+FW){1'b0}}};
      w_sp_flags  = 5'b00100;
    end
  end

  logic signed [EXW-1:0] w_exp_sum;
  logic [AW-1:0]         w_acc_init;

  assign w_exp_sum  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - $signed(EXW'(BIAS));
  // Multiplier {1,Fa} zero-extended to 2N bits, with an implicit 0 below it.
  assign w_acc_init = {{H{1'b0}}, {(2*N-MW){1'b0}}, 1'b1, w_fa, 1'b0};

  // ---------------- Booth step ------------------------------------------
  logic [2:0]            w_digit;
  logic [H-1:0]          w_m1, w_m2, w_pp, w_hi_sum;
  logic signed [AW-1:0]  w_acc_sum;
  logic [AW-1:0]         w_acc_shift;

  assign w_digit = r_acc[2:0];
  assign w_m1    = {{(H-MW){1'b0}}, r_mcand};
  assign w_m2    = {w_m1[H-2:0], 1'b0};

  // Partial product selected by the current radix-4 Booth digit.
  always_comb begin
    w_pp = {H{1'b0}};
    case (w_digit)
      3'b001, 3'b010: w_pp = w_m1;
      3'b011:         w_pp = w_m2;
      3'b100:         w_pp = -w_m2;
      3'b101, 3'b110: w_pp = -w_m1;
      default:        w_pp = {H{1'b0}};
    endcase
  end

  assign w_hi_sum    = r_acc[AW-1:2*N+1] + w_pp;
  assign w_acc_sum   = {w_hi_sum, r_acc[2*N:0]};
  assign w_acc_shift = w_acc_sum >>> 2;

  // ---------------- normalise / round -----------------------------------
  logic [PW-1:0]         w_prod;
  logic                  w_norm;
  logic [MW-1:0]         w_mant;
  logic                  w_guard, w_sticky, w_round_up, w_rnd_carry;
  logic [MW:0]           w_mant_rnd;
  logic [FW-1:0]         w_frac;
  logic signed [EXW-1:0] w_exp_fin;

  // After the last step the product sits just above the spent prev bit.
  assign w_prod = r_acc[PW:1];
  assign w_norm = w_prod[PW-1];

  // Pick mantissa, guard and sticky for a product in [1,2) or [2,4).
  always_comb begin
    w_mant   = {MW{1'b0}};
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    if (w_norm) begin
      w_mant   = w_prod[PW-1:FW+1];
      w_guard  = w_prod[FW];
      w_sticky = |w_prod[FW-1:0];
    end else begin
      w_mant   = w_prod[PW-2:FW];
      w_guard  = w_prod[FW-1];
      w_sticky = |w_prod[FW-2:0];
    end
  end

  assign w_round_up  = ~r_rnd & w_guard & (w_sticky | w_mant[0]);
  assign w_mant_rnd  = {1'b0, w_mant} + {{MW{1'b0}}, w_round_up};
  assign w_rnd_carry = w_mant_rnd[MW];
  // A rounding carry leaves 1.000..; shifting it back keeps the fraction zero.
  assign w_frac      = w_rnd_carry ? w_mant_rnd[FW:1] : w_mant_rnd[FW-1:0];
  assign w_exp_fin   = r_exp + $signed({{(EXW-1){1'b0}}, w_norm})
                             + $signed({{(EXW-1){1'b0}}, w_rnd_carry});

  logic [W-1:0] w_nm_result;
  logic [4:0]   w_nm_flags;

  // Range check of the final exponent: saturate to inf or flush to zero.
  always_comb begin
    w_nm_result = {W{1'b0}};
    w_nm_flags  = 5'b00000;
    if (w_exp_fin >= EXP_SAT) begin
      w_nm_result = {r_sign, {EW{1'b1}}, {FW{1'b0}}};
      w_nm_flags  = 5'b01010;
    end else if (w_exp_fin <= EXP_ZERO) begin
      w_nm_result = {r_sign, {(EW+FW){1'b0}}};
      w_nm_flags  = 5'b00101;
    end else begin
      w_nm_result = {r_sign, w_exp_fin[EW-1:0], w_frac};
      w_nm_flags  = 5'b00000;
    end
  end

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_acc       <= {AW{1'b0}};
      r_mcand     <= {MW{1'b0}};
      r_exp       <= {EXW{1'b0}};
      r_sign      <= 1'b0;
      r_rnd       <= 1'b0;
      r_result    <= {W{1'b0}};
      r_flags     <= 5'b00000;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_sign  <= w_sign;
            r_rnd   <= bus.rnd_mode;
            r_exp   <= w_exp_sum;
            r_mcand <= {1'b1, w_fb};
            r_cnt   <= {CW{1'b0}};
            if (w_special) begin
              r_result    <= w_sp_result;
              r_flags     <= w_sp_flags;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_acc   <= w_acc_init;
              r_state <= ST_BOOTH;
            end
          end
        end
        ST_BOOTH: begin
          r_acc <= w_acc_shift;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= {CW{1'b0}};
            r_state <= ST_NORM;
          end else begin
            r_cnt <= r_cnt + CW'(1'b1);
          end
        end
        ST_NORM: begin
          r_result    <= w_nm_result;
          r_flags     <= w_nm_flags;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

endmodule

// File: tb/tb_fp_mult_iter.sv
// ---------------------------------------------------------------------------
// tb_fp_mult_iter
// Directed and randomized checks of fp_mult_iter (single precision) against
// an integer-arithmetic reference model of the multiply/round rules.
// ---------------------------------------------------------------------------
module tb_fp_mult_iter;

  localparam int EW       = 8;
  localparam int FW       = 23;
  localparam int N        = (FW + 3) / 2;
  localparam int NORM_LAT = N + 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fp_mult_iter_if #(.EW(EW), .FW(FW)) bus ();

  fp_mult_iter #(.EW(EW), .FW(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer product, then round by comparing the discarded
  // remainder with one half ulp.
  function automatic void ref_mult(input logic [31:0] a, input logic [31:0] b, input logic rnd,
                                   output logic [31:0] res, output logic [4:0] fl,
                                   output bit special);
    int ea, eb, e, sh;
    longint unsigned fa, fb, p, q, rem, half;
    bit s, a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = 64'(a[22:0]);
    fb = 64'(b[22:0]);
    s  = a[31] ^ b[31];
    a_zero = (ea == 0);
    a_inf  = (ea == 255) && (fa == 0);
    a_nan  = (ea == 255) && (fa != 0);
    b_zero = (eb == 0);
    b_inf  = (eb == 255) && (fb == 0);
    b_nan  = (eb == 255) && (fb != 0);
    special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    res = 32'h0;
    fl  = 5'b00000;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      res = 32'h7FC00000;
      fl  = 5'b10000;
    end else if (a_inf || b_inf) begin
      res = {s, 8'hFF, 23'd0};
      fl  = 5'b01000;
    end else if (a_zero || b_zero) begin
      res = {s, 31'd0};
      fl  = 5'b00100;
    end else begin
      p = ((64'd1 << 23) | fa) * ((64'd1 << 23) | fb);
      e = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e  = e + 1;
      end else begin
        sh = 23;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (!rnd && ((rem > half) || (rem == half && q[0]))) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0};
        fl  = 5'b01010;
      end else if (e <= 0) begin
        res = {s, 31'd0};
        fl  = 5'b00101;
      end else begin
        res = {s, 8'(e), 23'(q)};
        fl  = 5'b00000;
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    int sel, e;
    r   = $urandom;
    sel = int'($urandom_range(0, 9));
    if (sel == 0)      e = ($urandom_range(0, 1) == 0) ? 0 : 255;
    else if (sel == 1) e = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(240, 254));
    else               e = int'($urandom_range(100, 154));
    r[30:23] = 8'(e);
    if (sel == 0 && $urandom_range(0, 1) == 0) r[22:0] = 23'd0;
    return r;
  endfunction

  // One full transaction with out_ready held high; checks result, flags and
  // latency counted in edges from the accepting edge inclusive.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic rnd, input string tag);
    logic [31:0] e_res;
    logic [4:0]  e_fl;
    bit          sp;
    int          lat;
    int          guard;
    ref_mult(a, b, rnd, e_res, e_fl, sp);
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    bus.a         = a;
    bus.b         = b;
    bus.rnd_mode  = rnd;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "/valid"},   32'(bus.out_valid), 32'd1);
    check({tag, "/result"},  bus.result, e_res);
    check({tag, "/flags"},   32'(bus.flags), 32'(e_fl));
    check({tag, "/latency"}, 32'(lat), sp ? 32'd1 : 32'(NORM_LAT));
    tick();
  endtask

  initial begin
    logic [31:0] e_res;
    logic [4:0]  e_fl;
    bit          sp;
    int          guard;

    bus.in_valid  = 1'b0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.rnd_mode  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset state
    #12;
    check("reset/out_valid", 32'(bus.out_valid), 32'd0);
    check("reset/result",    bus.result, 32'h0);
    check("reset/flags",     32'(bus.flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("reset/in_ready",  32'(bus.in_ready), 32'd1);

    // Directed vectors
    run_op(32'h3FC00000, 32'h40000000, 1'b0, "basic_rne");
    run_op(32'h3FC00000, 32'h3F800001, 1'b0, "tie_rne");
    run_op(32'h3FC00000, 32'h3F800001, 1'b1, "tie_trunc");
    run_op(32'h7F000000, 32'hFF000000, 1'b0, "overflow");
    run_op(32'h00800000, 32'h00800000, 1'b0, "underflow");
    run_op(32'h7F800000, 32'h00000000, 1'b0, "inf_x_zero");
    run_op(32'h00000001, 32'h3F800000, 1'b0, "denorm");
    run_op(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, "round_carry");
    run_op(32'hFF800000, 32'hC0000000, 1'b0, "neg_inf");
    run_op(32'h80000000, 32'h40400000, 1'b0, "neg_zero");
    run_op(32'h7FC12345, 32'h3F800000, 1'b1, "nan_in");

    // Result held in DONE while out_ready is low
    ref_mult(32'h40490FDB, 32'hC0000000, 1'b0, e_res, e_fl, sp);
    bus.a         = 32'h40490FDB;
    bus.b         = 32'hC0000000;
    bus.rnd_mode  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    check("hold/valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 1);
      bus.a        = $urandom;
      bus.b        = $urandom;
      tick();
      check("hold/result",   bus.result, e_res);
      check("hold/flags",    32'(bus.flags), 32'(e_fl));
      check("hold/out_valid", 32'(bus.out_valid), 32'd1);
      check("hold/in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("release/out_valid", 32'(bus.out_valid), 32'd0);
    check("release/in_ready",  32'(bus.in_ready), 32'd1);
    run_op(32'h40A00000, 32'h3E800000, 1'b0, "after_hold");

    // Reset during Booth iteration 6
    bus.a         = 32'h3FC00000;
    bus.b         = 32'h40000000;
    bus.rnd_mode  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort/out_valid", 32'(bus.out_valid), 32'd0);
    check("abort/result",    bus.result, 32'h0);
    check("abort/flags",     32'(bus.flags), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort/hold_valid", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort/in_ready",  32'(bus.in_ready), 32'd1);
    check("abort/no_output", 32'(bus.out_valid), 32'd0);
    run_op(32'h3FC00000, 32'h40000000, 1'b0, "post_abort");

    // Randomized vectors
    for (int i = 0; i < 40; i++) begin
      run_op(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
